// File: rtl/cpu_sdram_bridge.sv
// CPU / SPI-loader to SDRAM request-port bridge: arbitration, SPI byte packing, DTACK generation.
// Optional bus-error timeout enabled by defining BRIDGE_TIMEOUT_EN.
`timescale 1ns/1ps
module cpu_sdram_bridge #(
    parameter int C_ADDR_BITS = 23,
    parameter int C_TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_sel,
    input  logic                   cpu_as_n,
    input  logic                   cpu_uds_n,
    input  logic                   cpu_lds_n,
    input  logic                   cpu_rw,
    input  logic [C_ADDR_BITS-1:0] cpu_a,
    input  logic [15:0]            cpu_dout,
    output logic [15:0]            cpu_din,
    output logic                   dtack_n,
    output logic                   berr_n,
    input  logic                   spi_wr,
    input  logic                   spi_rd,
    input  logic [C_ADDR_BITS:0]   spi_addr,
    input  logic [7:0]             spi_wdata,
    output logic [7:0]             spi_rdata,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [C_ADDR_BITS-1:0] mem_addr,
    output logic [1:0]             mem_be,
    output logic [15:0]            mem_wdata,
    input  logic                   mem_ack,
    input  logic [15:0]            mem_rdata
);
    typedef enum logic [1:0] {IDLE, CPU_ACC, CPU_HOLD, SPI_ACC} state_e;

    state_e                 state_q;
    logic                   spi_wr_q, spi_rd_q, spi_wpend_q, spi_rpend_q, spi_wpend_d, spi_rpend_d;
    logic                   serve_wr_q, cpu_pend_q, as_lost_q, dtack_n_q;
    logic [7:0]             hi_q, lo_q, spi_rdata_q;
    logic [15:0]            cpu_din_q, mem_wdata_q;
    logic                   mem_req_q, mem_we_q;
    logic [C_ADDR_BITS-1:0] mem_addr_q;
    logic [1:0]             mem_be_q;

    logic wr_rise, rd_rise, wr_odd_rise, spi_w_go, spi_r_go, cpu_start;
    assign wr_rise     = spi_wr & ~spi_wr_q;
    assign rd_rise     = spi_rd & ~spi_rd_q;
    assign wr_odd_rise = wr_rise & spi_addr[0];
    // A fresh edge counts immediately so SPI wins against a CPU strobe in the same cycle.
    assign spi_w_go    = spi_wpend_q | wr_odd_rise;
    assign spi_r_go    = spi_rpend_q | rd_rise;
    assign cpu_start   = cpu_sel & ~cpu_as_n & ~(cpu_uds_n & cpu_lds_n) & ~cpu_pend_q;

    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        spi_wpend_d = wr_odd_rise | spi_wpend_q;
        spi_rpend_d = rd_rise | spi_rpend_q;
        if (state_q == SPI_ACC && mem_ack) begin
            // A new edge in the ack cycle wins over the clear.
            if (serve_wr_q) spi_wpend_d = wr_odd_rise;
            else            spi_rpend_d = rd_rise;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(C_TIMEOUT + 1) > 8) ? $clog2(C_TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt_q;
    logic             berr_n_q;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            spi_wr_q    <= 1'b0;
            spi_rd_q    <= 1'b0;
            spi_wpend_q <= 1'b0;
            spi_rpend_q <= 1'b0;
            serve_wr_q  <= 1'b0;
            cpu_pend_q  <= 1'b0;
            as_lost_q   <= 1'b0;
            dtack_n_q   <= 1'b1;
            hi_q        <= '0;
            lo_q        <= '0;
            spi_rdata_q <= '0;
            cpu_din_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
            berr_n_q    <= 1'b1;
`endif
        end else begin
            spi_wr_q    <= spi_wr;
            spi_rd_q    <= spi_rd;
            spi_wpend_q <= spi_wpend_d;
            spi_rpend_q <= spi_rpend_d;
            if (wr_rise) begin
                if (spi_addr[0]) lo_q <= spi_wdata;
                else             hi_q <= spi_wdata;
            end
            if (cpu_as_n) cpu_pend_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            if (cpu_as_n) berr_n_q <= 1'b1;
`endif
            case (state_q)
                IDLE: begin
                    if (spi_w_go || spi_r_go) begin
                        state_q     <= SPI_ACC;
                        mem_req_q   <= 1'b1;
                        serve_wr_q  <= spi_w_go;
                        mem_we_q    <= spi_w_go;
                        mem_addr_q  <= spi_addr[C_ADDR_BITS:1];
                        mem_be_q    <= 2'b11;
                        mem_wdata_q <= {hi_q, wr_odd_rise ? spi_wdata : lo_q};
                    end else if (cpu_start) begin
                        state_q     <= CPU_ACC;
                        cpu_pend_q  <= 1'b1;
                        as_lost_q   <= 1'b0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ~cpu_rw;
                        mem_addr_q  <= cpu_a;
                        mem_be_q    <= cpu_rw ? 2'b11 : {~cpu_uds_n, ~cpu_lds_n};
                        mem_wdata_q <= cpu_dout;
`ifdef BRIDGE_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                CPU_ACC: begin
                    if (cpu_as_n) as_lost_q <= 1'b1;
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) cpu_din_q <= mem_rdata;
                        if (as_lost_q || cpu_as_n) begin
                            state_q <= IDLE;
                        end else begin
                            dtack_n_q <= 1'b0;
                            state_q   <= CPU_HOLD;
                        end
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(C_TIMEOUT - 1)) begin
                        mem_req_q <= 1'b0;
                        berr_n_q  <= cpu_as_n | as_lost_q;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                CPU_HOLD: begin
                    if (cpu_as_n) begin
                        dtack_n_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                SPI_ACC: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!serve_wr_q) spi_rdata_q <= spi_addr[0] ? mem_rdata[7:0] : mem_rdata[15:8];
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_din   = cpu_din_q;
    assign dtack_n   = dtack_n_q;
    assign spi_rdata = spi_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
`ifdef BRIDGE_TIMEOUT_EN
    assign berr_n    = berr_n_q;
`else
    assign berr_n    = 1'b1;
`endif
endmodule
